// File: rtl/apb_bridge_fsm.sv
// ----------------------------------------------------------------------------
// apb_bridge_fsm
//
// Purpose:
//    AHB-to-APB bridge controller. It accepts AHB NONSEQ/SEQ transfers that
//    fall inside the APB window 0x8000_0000-0x8BFF_FFFF. For each one it runs
//    an APB setup/access pair on one of SLAVES slave selects. It also holds
//    the AHB side in wait states until the APB access completes.
//
// Compile-time option:
//    BRIDGE_ERR_RESP_EN - when defined, an active transfer whose address is
//                         outside the APB window gets a two-cycle AHB ERROR
//                         response (ERR1, ERR2). When undefined, such a
//                         transfer is ignored.
//
// Ports:
//    clock      in   system clock; all state changes on its rising edge
//    Hresetn    in   asynchronous active-low reset
//    Htrans     in   AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//    Hreadyin   in   AHB ready from the bus (address phase qualifier)
//    Hwrite     in   AHB direction, 1 = write
//    Haddr      in   AHB address
//    Hwdata     in   AHB write data (data phase)
//    Prdata     in   APB read data from the selected slave
//    Hreadyout  out  AHB ready back to the master (0 = wait state)
//    Hresp      out  AHB response (00 OKAY, 01 ERROR)
//    Hrdata     out  AHB read data; passes Prdata through during RENABLE only
//    Paddr      out  APB address (address of the last accepted transfer)
//    Pwdata     out  APB write data
//    Pwrite     out  APB direction
//    Penable    out  APB access-phase strobe
//    Pselx      out  APB one-hot slave selects
// ----------------------------------------------------------------------------
module apb_bridge_fsm #(
   parameter int WIDTH  = 32,
   parameter int SLAVES = 3
) (
   input  logic              clock,
   input  logic              Hresetn,
   input  logic [1:0]        Htrans,
   input  logic              Hreadyin,
   input  logic              Hwrite,
   input  logic [WIDTH-1:0]  Haddr,
   input  logic [WIDTH-1:0]  Hwdata,
   input  logic [WIDTH-1:0]  Prdata,
   output logic              Hreadyout,
   output logic [1:0]        Hresp,
   output logic [WIDTH-1:0]  Hrdata,
   output logic [WIDTH-1:0]  Paddr,
   output logic [WIDTH-1:0]  Pwdata,
   output logic              Pwrite,
   output logic              Penable,
   output logic [SLAVES-1:0] Pselx
);

   // state    | meaning
   // ---------+-------------------------------------------------------------
   // IDLE     | no APB activity; ready to accept an AHB transfer
   // READ     | APB read setup phase (Psel up, Penable low); AHB stalled
   // RENABLE  | APB read access phase; Prdata returned; may accept next
   // WWAIT    | write address accepted; waits for AHB data phase (Hwdata)
   // WRITE    | APB write setup phase; AHB stalled
   // WENABLE  | APB write access phase; may accept next transfer
   // ERR1     | first ERROR response cycle (Hreadyout low)
   // ERR2     | second ERROR response cycle (Hreadyout high)

`ifdef BRIDGE_ERR_RESP_EN
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_RENABLE = 3'd2,
      ST_WWAIT   = 3'd3,
      ST_WRITE   = 3'd4,
      ST_WENABLE = 3'd5,
      ST_ERR1    = 3'd6,
      ST_ERR2    = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_RENABLE = 3'd2,
      ST_WWAIT   = 3'd3,
      ST_WRITE   = 3'd4,
      ST_WENABLE = 3'd5
   } state_t;
`endif

   localparam logic [WIDTH-1:0] MAP_LO = WIDTH'(32'h8000_0000);
   localparam logic [WIDTH-1:0] MAP_HI = WIDTH'(32'h8BFF_FFFF);

   state_t            state;
   state_t            state_nxt;

   logic [WIDTH-1:0]  addr_q;
   logic [WIDTH-1:0]  pwdata_q;
   logic [SLAVES-1:0] sel_q;
   logic              write_q;

   logic              htrans_act;
   logic              in_map;
   logic              valid;
   logic              accept_state;
   logic              take;
   logic [SLAVES-1:0] sel_dec;

   // An active AHB address phase: NONSEQ or SEQ while the bus is ready.
   assign htrans_act   = Hreadyin & Htrans[1];
   assign in_map       = (Haddr >= MAP_LO) && (Haddr <= MAP_HI);
   assign valid        = htrans_act & in_map;

   // New transfers are only taken where Hreadyout is high and the APB side is
   // free or finishing its access phase, giving back-to-back transfers.
   assign accept_state = (state == ST_IDLE) || (state == ST_RENABLE) ||
                         (state == ST_WENABLE);
   assign take         = accept_state & valid;

   always_comb begin
      sel_dec = '0;
      case (Haddr[27:26])
         2'b00:   sel_dec = SLAVES'(1);
         2'b01:   sel_dec = SLAVES'(2);
         2'b10:   sel_dec = SLAVES'(4);
         default: sel_dec = '0;
      endcase
   end

   always_ff @(posedge clock or negedge Hresetn) begin
      if (!Hresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge Hresetn) begin
      if (!Hresetn) begin
         addr_q  <= '0;
         sel_q   <= '0;
         write_q <= 1'b0;
      end else if (take) begin
         addr_q  <= Haddr;
         sel_q   <= sel_dec;
         write_q <= Hwrite;
      end
   end

   // Hwdata belongs to the AHB data phase, which is the WWAIT cycle.
   always_ff @(posedge clock or negedge Hresetn) begin
      if (!Hresetn) begin
         pwdata_q <= '0;
      end else if (state == ST_WWAIT) begin
         pwdata_q <= Hwdata;
      end
   end

   always_comb begin
      state_nxt = state;
      Pselx     = '0;
      Penable   = 1'b0;
      Pwrite    = 1'b0;
      Hreadyout = 1'b1;
      Hresp     = 2'b00;
      Hrdata    = '0;

      case (state)
         ST_IDLE, ST_RENABLE, ST_WENABLE: begin
            if (valid) begin
               state_nxt = Hwrite ? ST_WWAIT : ST_READ;
            end
`ifdef BRIDGE_ERR_RESP_EN
            else if (htrans_act) begin
               state_nxt = ST_ERR1;
            end
`endif
            else begin
               state_nxt = ST_IDLE;
            end

            if (state == ST_RENABLE) begin
               Pselx   = sel_q;
               Penable = 1'b1;
               Hrdata  = Prdata;
            end else if (state == ST_WENABLE) begin
               Pselx   = sel_q;
               Penable = 1'b1;
               Pwrite  = write_q;
            end
         end

         ST_READ: begin
            state_nxt = ST_RENABLE;
            Pselx     = sel_q;
            Hreadyout = 1'b0;
         end

         ST_WWAIT: begin
            state_nxt = ST_WRITE;
            Hreadyout = 1'b0;
         end

         ST_WRITE: begin
            state_nxt = ST_WENABLE;
            Pselx     = sel_q;
            Pwrite    = write_q;
            Hreadyout = 1'b0;
         end

`ifdef BRIDGE_ERR_RESP_EN
         ST_ERR1: begin
            state_nxt = ST_ERR2;
            Hreadyout = 1'b0;
            Hresp     = 2'b01;
         end

         ST_ERR2: begin
            state_nxt = ST_IDLE;
            Hresp     = 2'b01;
         end
`endif

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign Paddr  = addr_q;
   assign Pwdata = pwdata_q;

endmodule

// File: tb/tb_apb_bridge_fsm.sv
module tb_apb_bridge_fsm;

   localparam int WIDTH  = 32;
   localparam int SLAVES = 3;

   localparam logic [1:0] ID = 2'b00;
   localparam logic [1:0] BZ = 2'b01;
   localparam logic [1:0] NS = 2'b10;
   localparam logic [1:0] SQ = 2'b11;

   logic              clock;
   logic              Hresetn;
   logic [1:0]        Htrans;
   logic              Hreadyin;
   logic              Hwrite;
   logic [WIDTH-1:0]  Haddr;
   logic [WIDTH-1:0]  Hwdata;
   logic [WIDTH-1:0]  Prdata;
   logic              Hreadyout;
   logic [1:0]        Hresp;
   logic [WIDTH-1:0]  Hrdata;
   logic [WIDTH-1:0]  Paddr;
   logic [WIDTH-1:0]  Pwdata;
   logic              Pwrite;
   logic              Penable;
   logic [SLAVES-1:0] Pselx;

   int tests;
   int fails;

   apb_bridge_fsm #(.WIDTH(WIDTH), .SLAVES(SLAVES)) dut (
      .clock     (clock),
      .Hresetn   (Hresetn),
      .Htrans    (Htrans),
      .Hreadyin  (Hreadyin),
      .Hwrite    (Hwrite),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Prdata    (Prdata),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Pwrite    (Pwrite),
      .Penable   (Penable),
      .Pselx     (Pselx)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One record per cycle: inputs presented in a state, and the outputs
   // expected in that state (sampled before the rising edge consumes them).
   typedef struct {
      logic [1:0]  tr;
      logic        ry;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      logic [2:0]  sel;
      logic        en;
      logic        pw;
      logic        hry;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic        cpa;
      logic [31:0] pa;
      logic        cpw;
      logic [31:0] pwd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic [1:0] tr, input logic ry, input logic wr,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] prdata,
      input logic [2:0] sel, input logic en, input logic pw, input logic hry,
      input logic [1:0] resp, input logic [31:0] rdata,
      input logic cpa, input logic [31:0] pa, input logic cpw, input logic [31:0] pwd);
      vec_t v;
      v.tr = tr; v.ry = ry; v.wr = wr; v.addr = addr; v.wdata = wdata; v.prdata = prdata;
      v.sel = sel; v.en = en; v.pw = pw; v.hry = hry; v.resp = resp; v.rdata = rdata;
      v.cpa = cpa; v.pa = pa; v.cpw = cpw; v.pwd = pwd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] tr, input logic ry, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] prdata);
      Htrans = tr; Hreadyin = ry; Hwrite = wr; Haddr = addr; Hwdata = wdata; Prdata = prdata;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      Hresetn = 1'b0;
      drive(ID, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

      // idle expectation: sel 0, en 0, pw 0, rdy 1, resp 00, rdata 0
      // write 0x8000_0010 / DEADBEEF
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b00,32'h0, 1,32'h0,1,32'h0));
      vecs.push_back(mk(NS,1,1,32'h80000010,32'h0,32'h0,          3'b000,0,0,1,2'b00,32'h0, 1,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'hDEADBEEF,32'h0,          3'b000,0,0,0,2'b00,32'h0, 1,32'h80000010,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b001,0,1,0,2'b00,32'h0, 1,32'h80000010,1,32'hDEADBEEF));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b001,1,1,1,2'b00,32'h0, 1,32'h80000010,1,32'hDEADBEEF));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b00,32'h0, 0,32'h0,1,32'hDEADBEEF));
      // read 0x8400_0004; a NONSEQ write in READ must be ignored
      vecs.push_back(mk(NS,1,0,32'h84000004,32'h0,32'h12345678,   3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(NS,1,1,32'h80000000,32'h0,32'h12345678,   3'b010,0,0,0,2'b00,32'h0, 1,32'h84000004,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h12345678,          3'b010,1,0,1,2'b00,32'h12345678, 1,32'h84000004,0,32'h0));
      // read 0x8800_0000, write 0x8000_0020 in RENABLE, SEQ read in WENABLE
      vecs.push_back(mk(NS,1,0,32'h88000000,32'h0,32'h0,          3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b100,0,0,0,2'b00,32'h0, 1,32'h88000000,0,32'h0));
      vecs.push_back(mk(NS,1,1,32'h80000020,32'h0,32'hCAFEF00D,   3'b100,1,0,1,2'b00,32'hCAFEF00D, 1,32'h88000000,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0BADF00D,32'h0,          3'b000,0,0,0,2'b00,32'h0, 1,32'h80000020,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b001,0,1,0,2'b00,32'h0, 1,32'h80000020,1,32'h0BADF00D));
      vecs.push_back(mk(SQ,1,0,32'h84000100,32'h0,32'h0,          3'b001,1,1,1,2'b00,32'h0, 1,32'h80000020,1,32'h0BADF00D));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b010,0,0,0,2'b00,32'h0, 1,32'h84000100,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h55AA55AA,          3'b010,1,0,1,2'b00,32'h55AA55AA, 1,32'h84000100,0,32'h0));
      // BUSY and Hreadyin=0 at in-map addresses are ignored
      vecs.push_back(mk(BZ,1,0,32'h80000000,32'h0,32'h0,          3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(NS,0,1,32'h80000000,32'h0,32'h0,          3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b00,32'h0, 1,32'h84000100,0,32'h0));
      // out-of-map NONSEQ to 0x9000_0000, then just past the top at 0x8C00_0000
      vecs.push_back(mk(NS,1,0,32'h90000000,32'h0,32'h0,          3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
`ifdef BRIDGE_ERR_RESP_EN
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,0,2'b01,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b01,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(NS,1,1,32'h8C000000,32'h0,32'h0,          3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,0,2'b01,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b01,32'h0, 0,32'h0,0,32'h0));
`else
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(NS,1,1,32'h8C000000,32'h0,32'h0,          3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
`endif
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b000,0,0,1,2'b00,32'h0, 1,32'h84000100,0,32'h0));
      // top in-map word 0x8BFF_FFFC read; Hrdata must drop once out of RENABLE
      vecs.push_back(mk(NS,1,0,32'h8BFFFFFC,32'h0,32'h0,          3'b000,0,0,1,2'b00,32'h0, 0,32'h0,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0,                 3'b100,0,0,0,2'b00,32'h0, 1,32'h8BFFFFFC,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0F0F0F0F,          3'b100,1,0,1,2'b00,32'h0F0F0F0F, 1,32'h8BFFFFFC,0,32'h0));
      vecs.push_back(mk(ID,1,0,32'h0,32'h0,32'h0F0F0F0F,          3'b000,0,0,1,2'b00,32'h0, 1,32'h8BFFFFFC,0,32'h0));

      repeat (2) @(negedge clock);
      Hresetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         logic ok;
         @(negedge clock);
         drive(vecs[i].tr, vecs[i].ry, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].prdata);
         #1;
         ok = ({Pselx, Penable, Pwrite, Hreadyout, Hresp, Hrdata} ===
               {vecs[i].sel, vecs[i].en, vecs[i].pw, vecs[i].hry, vecs[i].resp, vecs[i].rdata});
         if (vecs[i].cpa && (Paddr !== vecs[i].pa))  ok = 1'b0;
         if (vecs[i].cpw && (Pwdata !== vecs[i].pwd)) ok = 1'b0;
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL vec%0d: got sel=%b en=%b pw=%b rdy=%b resp=%b rdata=%h paddr=%h pwdata=%h; expected sel=%b en=%b pw=%b rdy=%b resp=%b rdata=%h paddr=%h(chk %b) pwdata=%h(chk %b)",
                     i, Pselx, Penable, Pwrite, Hreadyout, Hresp, Hrdata, Paddr, Pwdata,
                     vecs[i].sel, vecs[i].en, vecs[i].pw, vecs[i].hry, vecs[i].resp, vecs[i].rdata,
                     vecs[i].pa, vecs[i].cpa, vecs[i].pwd, vecs[i].cpw);
         end
      end

      // Asynchronous reset in the middle of a write to slave 0.
      @(negedge clock);
      drive(NS, 1'b1, 1'b1, 32'h80000000, 32'h0, 32'h0);
      @(negedge clock);
      drive(ID, 1'b1, 1'b0, 32'h0, 32'h11111111, 32'h0);
      @(negedge clock);
      drive(ID, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("pre_reset_write", {61'h0, Pselx}, {61'h0, 3'b001});
      Hresetn = 1'b0;
      #1;
      chk("rst_mid_write_sel", {61'h0, Pselx}, 64'h0);
      chk("rst_mid_write_ctl", {59'h0, Penable, Pwrite, Hreadyout, Hresp}, {59'h0, 5'b00100});
      chk("rst_mid_write_pa_pw", {Paddr, Pwdata}, 64'h0);

      // First valid transfer is taken on the first edge after release.
      @(negedge clock);
      Hresetn = 1'b1;
      drive(NS, 1'b1, 1'b0, 32'h84000008, 32'h0, 32'h0);
      @(negedge clock);
      drive(ID, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("post_reset_read", {Paddr, 25'h0, Pselx, Penable, Hreadyout, Hresp},
          {32'h84000008, 25'h0, 3'b010, 1'b0, 1'b0, 2'b00});
      @(negedge clock);
      Prdata = 32'h9ABCDEF0;
      #1;
      chk("post_reset_renable", {Hrdata, 28'h0, Penable, Hreadyout, Pwrite, 1'b0},
          {32'h9ABCDEF0, 28'h0, 1'b1, 1'b1, 1'b0, 1'b0});

      // Reset during RENABLE: access strobes and read data path drop at once.
      Hresetn = 1'b0;
      #1;
      chk("rst_mid_renable", {Hrdata, 25'h0, Pselx, Penable, Hreadyout, Hresp},
          {32'h0, 25'h0, 3'b000, 1'b0, 1'b1, 2'b00});
      @(negedge clock);
      Hresetn = 1'b1;
      @(negedge clock);
      #1;
      chk("idle_after_release", {58'h0, Pselx, Penable, Hreadyout, Hresp},
          {58'h0, 3'b000, 1'b0, 1'b1, 2'b00});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_bridge_fsm.md
APB_BRIDGE_FSM -- requirements
Module: apb_bridge_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the address and data width.
REQ-002 SHALL have parameter SLAVES, default 3, giving the number of APB slave selects.
REQ-003 SHALL have `clock` (input, 1): the single clock; all state changes on its rising edge.
REQ-004 SHALL have `Hresetn` (input, 1): reset, asynchronous and active-low.
REQ-005 SHALL have inputs Htrans (2), Hreadyin (1), Hwrite (1), Haddr (WIDTH), Hwdata (WIDTH) from the AHB master.
REQ-006 SHALL have input Prdata (WIDTH): APB read data.
REQ-007 SHALL have outputs Hreadyout (1), Hresp (2) and Hrdata (WIDTH) to the AHB master.
REQ-008 SHALL have outputs Paddr (WIDTH), Pwdata (WIDTH), Pwrite (1), Penable (1) and Pselx (SLAVES) to the APB slaves.

Function
REQ-009 SHALL treat a transfer as valid when Hreadyin=1, Htrans is 2'b10 or 2'b11, and Haddr is in 0x8000_0000-0x8BFF_FFFF; IDLE and BUSY transfers SHALL be ignored.
REQ-010 SHALL decode the slave from Haddr[27:26]: 00 gives Pselx=001, 01 gives 010, 10 gives 100.
REQ-011 SHALL register Haddr, Hwrite and the decoded select on every rising edge where a valid transfer is accepted.
REQ-012 SHALL implement states IDLE, READ, RENABLE, WWAIT, WRITE and WENABLE, plus ERR1 and ERR2 when BRIDGE_ERR_RESP_EN is defined.
REQ-013 IDLE SHALL go to READ on a valid read, to WWAIT on a valid write, and otherwise stay in IDLE.
REQ-014 READ SHALL always go to RENABLE; WWAIT SHALL always go to WRITE; WRITE SHALL always go to WENABLE.
REQ-015 RENABLE and WENABLE SHALL accept a new transfer exactly as IDLE does, giving back-to-back APB transfers with no IDLE cycle.
REQ-016 SHALL latch Hwdata into Pwdata on the WWAIT-to-WRITE edge.
REQ-017 SHALL drive Pselx = registered select in READ, RENABLE, WRITE and WENABLE, and 0 elsewhere.
REQ-018 SHALL drive Penable=1 only in RENABLE and WENABLE.
REQ-019 SHALL drive Pwrite=1 in WRITE and WENABLE, and Paddr = registered address.
REQ-020 SHALL drive Hreadyout=0 in READ, WWAIT, WRITE and ERR1, and 1 elsewhere.
REQ-021 SHALL drive Hrdata = Prdata in RENABLE, and 0 otherwise (combinational path).
REQ-022 Latency: read = 2 cycles after the address phase, with data in RENABLE; write = 3 cycles (WWAIT, WRITE, WENABLE).
REQ-023 SHALL drive Hresp=2'b00 (OKAY) except as stated in REQ-028.
REQ-024 SHALL ignore any AHB input change while in READ, WWAIT or WRITE.

Reset
REQ-025 On Hresetn=0 the state SHALL go to IDLE immediately, without waiting for a clock edge, including mid-transfer.
REQ-026 Reset values SHALL be: Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, Hresp=00, Hrdata=0.
REQ-027 After Hresetn deasserts, the first valid transfer SHALL be accepted on the first rising edge.

Configuration
REQ-028 With BRIDGE_ERR_RESP_EN defined:
- A transfer with Hreadyin=1, Htrans NONSEQ/SEQ and an address outside the map (REQ-009) SHALL go to ERR1, then ERR2, then IDLE.
- ERR1 and ERR2 SHALL drive Hresp=2'b01, with Hreadyout=0 in ERR1 and Hreadyout=1 in ERR2.
- No Pselx SHALL assert in ERR1 or ERR2.
REQ-029 Without BRIDGE_ERR_RESP_EN, out-of-map transfers SHALL be ignored: Hresp=00, Hreadyout=1, no APB activity.

Verification
REQ-030 Reset: assert Hresetn=0 mid-WRITE (Pselx=001) -> Pselx=0, Penable=0 and Hreadyout=1 before the next clock edge.
REQ-031 Single write, Haddr=0x8000_0010, Hwdata=0xDEADBEEF:
- Hreadyout low for 2 cycles.
- WRITE cycle: Pselx=001, Pwrite=1, Penable=0, Paddr=0x8000_0010, Pwdata=0xDEADBEEF.
- Next cycle: Penable=1, Hreadyout=1.
REQ-032 Single read, Haddr=0x8400_0004, Prdata=0x1234_5678 -> READ: Pselx=010, Penable=0, Hreadyout=0; RENABLE: Penable=1, Hreadyout=1, Hrdata=0x1234_5678.
REQ-033 Read to 0x8800_0000 with a write to 0x8000_0020 presented in RENABLE -> Pselx goes 100 to 0 (WWAIT), then 001 (WRITE), with no IDLE state in between.
REQ-034 Htrans=2'b01 (BUSY) and Hreadyin=0 transfers at in-map addresses -> state stays IDLE and Pselx stays 0.
REQ-035 NONSEQ to 0x9000_0000:
- With BRIDGE_ERR_RESP_EN: Hresp=01 for 2 cycles, with Hreadyout 0 then 1, and Pselx=0.
- Without it: Hresp=00, Hreadyout=1, Pselx=0.
